// File: rtl/location_barcode_tx.sv
// Decodes a parking-slot location code back to its slot and direction, then
// streams the slot's 13-character ASCII barcode (optionally CR-terminated) over valid/ready.
module location_barcode_tx #(
    parameter bit          APPEND_CR = 1'b1,
    parameter logic [87:0] PREFIX    = 88'h39_37_38_37_33_35_38_39_37_35_32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] location,
    input  logic       loc_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy,
    output logic [4:0] slot_idx,
    output logic       dir_fetch,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_SEND   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = APPEND_CR ? 4'd13 : 4'd12;

    // Character idx of the barcode for a given slot; index 13 is the trailing CR.
    function automatic logic [7:0] char_at(input logic [3:0] idx, input logic [4:0] slot);
        logic [7:0] ch;
        logic [2:0] low;
        low = slot[2:0] - 3'd1;
        if (idx <= 4'd10) begin
            ch = 8'(PREFIX >> {(4'd10 - idx), 3'b000});
        end else if (idx == 4'd11) begin
            ch = (slot <= 5'd8) ? 8'h38 : 8'h39;
        end else if (idx == 4'd12) begin
            ch = {5'b00110, low};
        end else begin
            ch = 8'h0D;
        end
        return ch;
    endfunction

    state_t     r_state, w_state_nx;
    logic [6:0] r_loc, w_loc_nx;
    logic [3:0] r_idx, w_idx_nx;
    logic [7:0] r_tx_data, w_tx_data_nx;
    logic       r_tx_valid, w_tx_valid_nx;
    logic       r_busy, w_busy_nx;
    logic [4:0] r_slot, w_slot_nx;
    logic       r_dir, w_dir_nx;
    logic       r_done, w_done_nx;
    logic       r_err, w_err_nx;

    logic [2:0] w_col;
    logic       w_loc_ok;
    logic [4:0] w_dec_slot;

    // Row bits [6:5] pick the group of four slots, bit 4 is the save/fetch flag.
    assign w_col      = r_loc[3:1];
    assign w_loc_ok   = (r_loc[0] == 1'b0) && (w_col >= 3'd1) && (w_col <= 3'd4);
    assign w_dec_slot = {1'b0, r_loc[6:5], 2'b00} + {2'b00, w_col};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Datapath and output registers; everything the block presents is registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loc      <= 7'd0;
            r_idx      <= 4'd0;
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_slot     <= 5'd0;
            r_dir      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_loc      <= w_loc_nx;
            r_idx      <= w_idx_nx;
            r_tx_data  <= w_tx_data_nx;
            r_tx_valid <= w_tx_valid_nx;
            r_busy     <= w_busy_nx;
            r_slot     <= w_slot_nx;
            r_dir      <= w_dir_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nx    = r_state;
        w_loc_nx      = r_loc;
        w_idx_nx      = r_idx;
        w_tx_data_nx  = r_tx_data;
        w_tx_valid_nx = r_tx_valid;
        w_busy_nx     = r_busy;
        w_slot_nx     = r_slot;
        w_dir_nx      = r_dir;
        w_done_nx     = 1'b0;
        w_err_nx      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (loc_valid) begin
                    w_loc_nx   = location;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_DECODE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_DECODE: begin
                w_dir_nx = ~r_loc[4];
                if (w_loc_ok) begin
                    w_slot_nx     = w_dec_slot;
                    w_idx_nx      = 4'd0;
                    w_tx_valid_nx = 1'b1;
                    w_tx_data_nx  = char_at(4'd0, w_dec_slot);
                    w_state_nx    = S_SEND;
                end else begin
                    w_slot_nx  = 5'd0;
                    w_err_nx   = 1'b1;
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
            S_SEND: begin
                if (r_tx_valid && tx_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_tx_valid_nx = 1'b0;
                        w_tx_data_nx  = 8'd0;
                        w_busy_nx     = 1'b0;
                        w_done_nx     = 1'b1;
                        w_state_nx    = S_DONE;
                    end else begin
                        w_idx_nx     = r_idx + 4'd1;
                        w_tx_data_nx = char_at(r_idx + 4'd1, r_slot);
                    end
                end else begin
                    w_state_nx = S_SEND;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx    = S_IDLE;
                w_tx_valid_nx = 1'b0;
                w_busy_nx     = 1'b0;
            end
        endcase
    end

    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = r_busy;
    assign slot_idx  = r_slot;
    assign dir_fetch = r_dir;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_location_barcode_tx.sv
// Scoreboard bench: requests push expected bytes/results, a negedge monitor pops and compares.
module tb_location_barcode_tx;

    typedef struct packed {
        logic       kind;   // 1 = err pulse, 0 = done pulse
        logic       dir;
        logic [4:0] slot;
    } res_t;

    logic       clk = 1'b0;
    logic       rst, loc_valid, tx_ready, sel, bp_mode;
    logic [6:0] location;
    logic [7:0] bp_cnt;
    int         n_vec = 0, n_fail = 0;

    logic [7:0] exp_q[$];
    res_t       res_q[$];
    logic       stab_pending;
    logic [7:0] stab_data;

    logic [7:0] d1_data, d0_data, m_data;
    logic       d1_valid, d1_busy, d1_dir, d1_done, d1_err;
    logic       d0_valid, d0_busy, d0_dir, d0_done, d0_err;
    logic [4:0] d1_slot, d0_slot, m_slot;
    logic       m_valid, m_busy, m_dir, m_done, m_err;

    logic [7:0] prefix [0:10] = '{8'h39, 8'h37, 8'h38, 8'h37, 8'h33, 8'h35,
                                  8'h38, 8'h39, 8'h37, 8'h35, 8'h32};

    // {location, slot, char11, char12} for every valid save code
    logic [27:0] sweep [0:15] = '{
        {7'h12, 5'd1,  8'h38, 8'h30}, {7'h14, 5'd2,  8'h38, 8'h31},
        {7'h16, 5'd3,  8'h38, 8'h32}, {7'h18, 5'd4,  8'h38, 8'h33},
        {7'h32, 5'd5,  8'h38, 8'h34}, {7'h34, 5'd6,  8'h38, 8'h35},
        {7'h36, 5'd7,  8'h38, 8'h36}, {7'h38, 5'd8,  8'h38, 8'h37},
        {7'h52, 5'd9,  8'h39, 8'h30}, {7'h54, 5'd10, 8'h39, 8'h31},
        {7'h56, 5'd11, 8'h39, 8'h32}, {7'h58, 5'd12, 8'h39, 8'h33},
        {7'h72, 5'd13, 8'h39, 8'h34}, {7'h74, 5'd14, 8'h39, 8'h35},
        {7'h76, 5'd15, 8'h39, 8'h36}, {7'h78, 5'd16, 8'h39, 8'h37}};

    always #5 clk = ~clk;

    location_barcode_tx #(.APPEND_CR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .location(location), .loc_valid(loc_valid & ~sel),
        .tx_ready(tx_ready), .tx_data(d1_data), .tx_valid(d1_valid), .busy(d1_busy),
        .slot_idx(d1_slot), .dir_fetch(d1_dir), .done(d1_done), .err(d1_err));

    location_barcode_tx #(.APPEND_CR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .location(location), .loc_valid(loc_valid & sel),
        .tx_ready(tx_ready), .tx_data(d0_data), .tx_valid(d0_valid), .busy(d0_busy),
        .slot_idx(d0_slot), .dir_fetch(d0_dir), .done(d0_done), .err(d0_err));

    assign m_data  = sel ? d0_data  : d1_data;
    assign m_valid = sel ? d0_valid : d1_valid;
    assign m_busy  = sel ? d0_busy  : d1_busy;
    assign m_slot  = sel ? d0_slot  : d1_slot;
    assign m_dir   = sel ? d0_dir   : d1_dir;
    assign m_done  = sel ? d0_done  : d1_done;
    assign m_err   = sel ? d0_err   : d1_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Monitor: byte handshakes, hold-under-backpressure, and done/err pulses.
    always @(negedge clk) begin
        if (rst) begin
            stab_pending = 1'b0;
        end else begin
            if (stab_pending) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, stab_data);
            end
            stab_pending = m_valid && !tx_ready;
            stab_data    = m_data;
            if (m_valid && tx_ready) begin
                if (exp_q.size() == 0) flag("unexpected_byte");
                else check("byte", m_data, exp_q.pop_front());
            end
            if (m_done || m_err) begin
                if (res_q.size() == 0) begin
                    flag("unexpected_done_err");
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("is_err", m_err, r.kind);
                    check("slot_idx", m_slot, r.slot);
                    if (!r.kind) check("dir_fetch", m_dir, r.dir);
                end
            end
        end
    end

    // Back-pressure: ready high one cycle in four.
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            bp_cnt   = bp_cnt + 8'd1;
            tx_ready = (bp_cnt[1:0] == 2'd3);
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((m_busy || m_done) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 400) flag("idle_timeout");
    endtask

    task automatic issue(input logic [6:0] loc, input bit ok, input logic [4:0] slot,
                         input bit dir, input logic [7:0] c11, input logic [7:0] c12,
                         input bit cr);
        res_t r;
        wait_idle();
        if (ok) begin
            for (int i = 0; i < 11; i++) exp_q.push_back(prefix[i]);
            exp_q.push_back(c11);
            exp_q.push_back(c12);
            if (cr) exp_q.push_back(8'h0D);
        end
        r.kind = !ok;
        r.dir  = dir;
        r.slot = ok ? slot : 5'd0;
        res_q.push_back(r);
        location  = loc;
        loc_valid = 1'b1;
        @(posedge clk); #1;
        loc_valid = 1'b0;
        check("busy_t1", m_busy, 1);
        check("valid_t1", m_valid, 0);
        @(posedge clk); #1;
        if (ok) begin
            check("valid_t2", m_valid, 1);
            check("first_byte", m_data, 8'h39);
        end else begin
            check("err_t2", m_err, 1);
            check("busy_t2", m_busy, 0);
            check("novalid_t2", m_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; loc_valid = 1'b0; tx_ready = 1'b1; sel = 1'b0;
        bp_mode = 1'b0; bp_cnt = 8'd0; location = 7'd0;
        stab_pending = 1'b0; stab_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", d1_data, 0);
        check("rst_valid", d1_valid, 0);
        check("rst_busy", d1_busy, 0);
        check("rst_slot", d1_slot, 0);
        check("rst_dir", d1_dir, 0);
        check("rst_done", d1_done, 0);
        check("rst_err", d1_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(7'b101_001_0, 1'b1, 5'd9, 1'b0, 8'h39, 8'h30, 1'b1);
        issue(7'b010_100_0, 1'b1, 5'd8, 1'b1, 8'h38, 8'h37, 1'b1);
        issue(7'd0,         1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 1'b1);
        issue(7'b011_101_0, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 1'b1);
        issue(7'b001_001_1, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 1'b1);

        bp_mode = 1'b1;
        issue(7'b011_011_0, 1'b1, 5'd7, 1'b0, 8'h38, 8'h36, 1'b1);
        wait_idle();
        bp_mode = 1'b0;
        tx_ready = 1'b1;

        // Request during SEND must be ignored.
        issue(7'b111_010_0, 1'b1, 5'd14, 1'b0, 8'h39, 8'h35, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        location  = 7'b000_001_0;
        loc_valid = 1'b1;
        @(posedge clk); #1;
        loc_valid = 1'b0;
        wait_idle();

        // Reset with byte 5 on the bus abandons the string without done.
        issue(7'b100_011_0, 1'b1, 5'd11, 1'b1, 8'h39, 8'h32, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("rst_mid_valid", d1_valid, 0);
        check("rst_mid_busy", d1_busy, 0);
        exp_q.delete();
        res_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("rst_mid_slot", d1_slot, 0);
        issue(7'b100_011_0, 1'b1, 5'd11, 1'b1, 8'h39, 8'h32, 1'b1);
        wait_idle();

        sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [27:0] v;
            v = sweep[i];
            issue(v[27:21], 1'b1, v[20:16], 1'b0, v[15:8], v[7:0], 1'b0);
        end
        wait_idle();
        repeat (2) begin @(posedge clk); #1; end
        check("bytes_left", exp_q.size(), 0);
        check("results_left", res_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/location_barcode_tx.md
Name: location_barcode_tx

Overview:
- Reverse path of the parking-slot address translation.
- Takes a 7-bit location code {row[2:0], col[2:0], 1'b0} and decodes it into a slot index (1..16) and a direction (save/fetch).
- Regenerates the 13-character ASCII barcode for that slot and streams it out one byte per valid/ready handshake.
- Sits between the slot controller and the display/UART byte sink; it echoes which ticket belongs to the slot that was just served.

Parameters:
- APPEND_CR, 1, when 1 a 0x0D byte follows the 13 barcode characters (14 bytes total); when 0 only 13 bytes are sent.
- PREFIX, 88'h39_37_38_37_33_35_38_39_37_35_32, the fixed 11-character ASCII prefix "97873589752", sent MSB byte first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- location  input  7  location code {row, col, 1'b0}.
- loc_valid  input  1  request strobe; sampled only when busy=0.
- tx_ready  input  1  byte sink ready.
- tx_data  output  8  ASCII byte being offered.
- tx_valid  output  1  tx_data valid.
- busy  output  1  high from acceptance until return to IDLE.
- slot_idx  output  5  decoded slot 1..16; 0 when invalid.
- dir_fetch  output  1  decoded direction: 1 = fetch (row[0]=0), 0 = save (row[0]=1).
- done  output  1  one-cycle pulse after the last byte handshake.
- err  output  1  one-cycle pulse when the location is invalid.

Behaviour:
- Reset (async, any state): FSM goes to IDLE. tx_data=0, tx_valid=0, busy=0, slot_idx=0, dir_fetch=0, done=0, err=0. The byte counter clears. Any transfer in progress is abandoned with no done pulse.
- Decode rules: g = row[2:1], col valid range 1..4, slot = g*4 + col.
  - Invalid if location[0]=1, col=0, or col>4.
  - Location 7'd0 is therefore invalid.
- Barcode layout: char0..10 = PREFIX; char11 = 0x38 ('8') if slot<=8, else 0x39 ('9'); char12 = 0x30 + ((slot-1) mod 8).
  - Example: row=3'b101, col=3'b001 gives slot 9 and "...9","0".
- FSM: IDLE -> DECODE -> SEND -> DONE -> IDLE.
  - IDLE: busy=0. loc_valid=1 at cycle T latches location; busy=1 from T+1. loc_valid during busy is ignored (no queueing).
  - DECODE (T+1): registers slot_idx and dir_fetch.
    - Invalid: slot_idx=0, err=1 during T+2 only, then IDLE (busy=0 at T+2). No byte is sent.
    - Valid: enter SEND with index 0.
  - SEND: tx_valid=1 and tx_data=char[index] starting at T+2.
    - On tx_valid & tx_ready the index increments and the next byte is presented the following cycle, so back-to-back transfer runs at one byte per cycle with tx_ready held high.
    - While tx_ready=0, tx_data and tx_valid hold stable.
    - After the handshake on the last byte (index 12, or 13 when APPEND_CR=1), tx_valid=0 next cycle and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle done is high.
- slot_idx and dir_fetch hold their value until the next accepted request or reset.
- Minimum request-to-request spacing with tx_ready always high: 2 + N + 1 cycles, where N = byte count (16 cycles for N=13, 17 cycles for N=14).

Test Plan:
- Reset, then location=7'b101_001_0 pulsed with tx_ready=1: tx_valid rises at T+2; bytes 39 37 38 37 33 35 38 39 37 35 32 39 30 0D on 14 consecutive cycles; slot_idx=9, dir_fetch=0; done pulses once.
- location=7'b010_100_0: slot_idx=8, dir_fetch=1; last two barcode bytes 38 37.
- location values 7'd0, 7'b011_101_0 and 7'b001_001_1: err pulses for 1 cycle at T+2; tx_valid never asserts; slot_idx=0; busy is low again at T+2.
- Random tx_ready back-pressure (e.g. low 3 cycles per byte): tx_data holds stable while tx_valid=1 and tx_ready=0; byte order and count are unchanged; exactly 14 handshakes occur.
- loc_valid re-pulsed with a different location mid-SEND: it is ignored and the current string completes unchanged. rst asserted at byte 5: tx_valid=0 immediately, no done pulse, and a following request starts again from byte 0.
- APPEND_CR=0, all 16 valid save codes swept: 13 bytes each; slot_idx 1..16 matches g*4+col; char11/char12 follow the '8'/'9' and 0x30+((slot-1) mod 8) rule.
